// File: rtl/corr_search_ctrl.sv
// Code-phase search controller: drives the 127-chip PN reference and dump pulses,
// scans every code phase once, realigns to the best one and tracks lock.
module corr_search_ctrl #(
  parameter int WINDOW = 4080,
  parameter int THRESH = 192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] corr_value,
  output logic       code_out,
  output logic       corr_rst,
  output logic       busy,
  output logic       done,
  output logic       locked,
  output logic [6:0] best_phase,
  output logic [7:0] best_value,
  output logic [7:0] track_value
);

  localparam int            WW       = $clog2(WINDOW);
  localparam logic [WW-1:0] WLAST    = WW'(WINDOW - 1);
  localparam logic [7:0]    LOCK_LVL = 8'(THRESH);
  localparam logic [7:0]    LOSS_LVL = 8'(THRESH >> 1);

  typedef enum logic [2:0] {IDLE, PRIME, MEASURE, ALIGN, PRIME_T, TRACK} state_t;

  state_t        state, state_nx;
  logic [6:0]    lfsr;
  logic [6:0]    k;
  logic [6:0]    align_cnt;
  logic [WW-1:0] wcnt;
  logic          sample;
  logic          miss;
  logic          slip;

  assign code_out = lfsr[0];
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    slip     = 1'b0;
    corr_rst = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = PRIME;
      end
      PRIME: begin
        corr_rst = (wcnt == WLAST);
        if (sample) state_nx = MEASURE;
      end
      MEASURE: begin
        corr_rst = (wcnt == WLAST);
        slip     = corr_rst;
        if (sample && k == 7'd126) begin
          done     = 1'b1;
          state_nx = ALIGN;
        end
      end
      ALIGN: begin
        // ALIGN lasts max(best_phase,1) cycles; the last slip and the lock decision share a cycle
        slip = (align_cnt < best_phase);
        if ({1'b0, align_cnt} + 8'd1 >= {1'b0, best_phase})
          state_nx = (best_value >= LOCK_LVL) ? PRIME_T : IDLE;
      end
      PRIME_T: begin
        corr_rst = (wcnt == WLAST);
        if (sample) state_nx = TRACK;
      end
      TRACK: begin
        corr_rst = (wcnt == WLAST);
        if (sample && corr_value < LOSS_LVL && miss) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= 7'h7F;
      wcnt        <= '0;
      k           <= '0;
      align_cnt   <= '0;
      sample      <= 1'b0;
      miss        <= 1'b0;
      locked      <= 1'b0;
      best_phase  <= '0;
      best_value  <= '0;
      track_value <= '0;
    end else begin
      state  <= state_nx;
      sample <= corr_rst;
      // x^7+x^6+1; holding for one cycle delays the code by one chip
      if (!slip) lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      if (state == IDLE || state == ALIGN || wcnt == WLAST)
        wcnt <= '0;
      else
        wcnt <= wcnt + WW'(1);
      align_cnt <= (state == ALIGN) ? align_cnt + 7'd1 : 7'd0;

      if (state == IDLE && start) begin
        best_value <= '0;
        best_phase <= '0;
        k          <= '0;
      end

      // strict compare keeps the lowest phase on ties
      if (state == MEASURE && sample) begin
        if (corr_value > best_value) begin
          best_value <= corr_value;
          best_phase <= k;
        end
        k <= k + 7'd1;
      end

      if (state == ALIGN && state_nx == PRIME_T) locked <= 1'b1;
      if (state == PRIME_T) miss <= 1'b0;

      if (state == TRACK && sample) begin
        track_value <= corr_value;
        if (corr_value < LOSS_LVL) begin
          if (miss) begin
            locked <= 1'b0;
            miss   <= 1'b0;
          end else begin
            miss <= 1'b1;
          end
        end else begin
          miss <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_corr_search_ctrl.sv
// Bench for corr_search_ctrl: a correlator environment plus a time-based model of the
// scan/align/track schedule, compared every cycle, with directed literal checks.
module tb_corr_search_ctrl;

  localparam int W  = 64;
  localparam int TH = 192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] corr_value;
  logic       code_out, corr_rst, busy, done, locked;
  logic [6:0] best_phase;
  logic [7:0] best_value, track_value;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int s_cyc = 0;

  always #5 clk = ~clk;

  corr_search_ctrl #(.WINDOW(W), .THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .corr_value(corr_value),
    .code_out(code_out), .corr_rst(corr_rst), .busy(busy), .done(done),
    .locked(locked), .best_phase(best_phase), .best_value(best_value),
    .track_value(track_value)
  );

  task automatic check_output(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // PN chips from the recurrence c[m] = c[m-7] ^ c[m-6], with c[-6..0] all ones
  bit seq[127];
  initial begin
    bit b[134];
    for (int j = 0; j < 7; j++) b[j] = 1'b1;
    for (int j = 7; j < 134; j++) b[j] = b[j-7] ^ b[j-6];
    for (int n = 0; n < 127; n++) seq[n] = b[n+6];
  end

  // Correlator environment: mode 0 = code delayed 5 chips, 1 = random, 2 = constant 200, 3 = inverted
  int         mode = 0;
  int         fr = 0;
  int         acc = 0;
  int         cor_sum;
  logic       rnd = 1'b0;
  logic       sig;
  logic [7:0] cq = 8'd0;

  always_comb begin
    sig = 1'b0;
    case (mode)
      0: sig = seq[(fr + 122) % 127];
      1: sig = rnd;
      3: sig = !seq[(fr + 122) % 127];
      default: sig = 1'b0;
    endcase
  end

  assign corr_value = (mode == 2) ? 8'd200 : cq;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      fr  <= 0;
      acc <= 0;
      cq  <= 8'd0;
    end else begin
      fr  <= (fr + 1) % 127;
      rnd <= 1'($urandom % 2);
      cor_sum = acc + ((code_out == sig) ? 1 : 0);
      if (corr_rst) begin
        cq  <= (cor_sum * 4 > 255) ? 8'd255 : 8'(cor_sum * 4);
        acc <= 0;
      end else begin
        acc <= cor_sum;
      end
    end
  end

  // Model: seg 0 idle, 1 scan (prime + 127 measure windows), 2 align, 3 prime_t + track.
  // t counts cycles since the segment began; dumps fall on multiples of W.
  bit mvalid = 1'b0;
  int seg = 0, t = 0, idx = 0;
  int e_best = 0, e_bp = 0, e_k = 0, e_track = 0;
  bit e_locked = 1'b0, m_miss = 1'b0;
  bit e_rst = 1'b0, e_sample = 1'b0, e_done = 1'b0, e_slip = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mvalid = 1'b1;
      seg = 0; t = 0; idx = 0;
      e_best = 0; e_bp = 0; e_k = 0; e_track = 0;
      e_locked = 1'b0; m_miss = 1'b0;
    end else if (mvalid) begin
      if (!e_slip) idx = (idx + 1) % 127;
      case (seg)
        0: if (start) begin
          seg = 1; t = 1; e_best = 0; e_bp = 0; e_k = 0;
        end
        1: begin
          if (e_sample && t > W + 1) begin
            if (int'(corr_value) > e_best) begin
              e_best = corr_value;
              e_bp   = e_k;
            end
            if (e_k == 126) begin
              seg = 2; t = 1;
            end else begin
              e_k++; t++;
            end
          end else begin
            t++;
          end
        end
        2: begin
          if (t >= e_bp) begin
            if (e_best >= TH) begin
              e_locked = 1'b1; seg = 3; t = 1; m_miss = 1'b0;
            end else begin
              seg = 0;
            end
          end else begin
            t++;
          end
        end
        default: begin
          if (e_sample && t > W + 1) begin
            e_track = corr_value;
            if (int'(corr_value) < TH / 2) begin
              if (m_miss) begin
                e_locked = 1'b0; seg = 0;
              end else begin
                m_miss = 1'b1;
              end
            end else begin
              m_miss = 1'b0;
            end
          end
          t++;
        end
      endcase
    end
    e_rst    = (seg == 1 || seg == 3) && (t % W == 0);
    e_sample = (seg == 1 || seg == 3) && (t % W == 1) && (t > 1);
    e_done   = (seg == 1) && (t == 128 * W + 1);
    e_slip   = (seg == 1 && e_rst && t >= 2 * W) || (seg == 2 && t <= e_bp);
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check_output("code_out", code_out, seq[idx]);
      check_output("corr_rst", corr_rst, e_rst);
      check_output("busy", busy, seg != 0);
      check_output("done", done, e_done);
      check_output("locked", locked, e_locked);
      check_output("best_phase", best_phase, e_bp);
      check_output("best_value", best_value, e_best);
      check_output("track_value", track_value, e_track);
    end
  end

  task automatic apply_stimulus(input bit record);
    start = 1'b1;
    if (record) s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic bit probe(input int sel);
    case (sel)
      0: return done;
      1: return locked;
      default: return busy;
    endcase
  endfunction

  // Waits until the selected output equals level; at = cycles since the recorded start
  task automatic wait_level(input string name, input int sel, input bit level,
                            input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (probe(sel) == level) begin
        at = cyc - s_cyc;
        break;
      end
    end
    if (at < 0) check_output({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int at, lk, ones;

    check_output("seq_head", {24'd0, seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6], seq[7]}, 8'b1000_0001);
    ones = 0;
    for (int n = 0; n < 127; n++) ones += seq[n];
    check_output("seq_ones", ones, 64);

    // Reset held with start high
    rst_n = 1'b0; start = 1'b1; mode = 0;
    repeat (3) @(negedge clk);
    check_output("rst_code_out", code_out, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_locked", locked, 0);
    check_output("rst_corr_rst", corr_rst, 0);
    check_output("rst_best_value", best_value, 0);
    start = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Acquisition against a 5-chip delay, then tracking
    apply_stimulus(1'b1);
    check_output("acq_busy_rise", busy, 1);
    wait_level("acq_done", 0, 1'b1, 130 * W, at);
    check_output("acq_done_cycle", at, 128 * W + 1);
    wait_level("acq_lock", 1, 1'b1, 200, lk);
    check_output("acq_lock_delay", lk - at, 6);
    check_output("acq_best_phase", best_phase, 5);
    check_output("acq_best_value", best_value, 255);
    repeat (2 * W + 4) @(negedge clk);
    check_output("acq_track_value", track_value, 255);
    check_output("acq_still_locked", locked, 1);

    // Lock loss with an inverted signal
    mode = 3;
    wait_level("loss_unlock", 1, 1'b0, 4 * W, at);
    check_output("loss_busy", busy, 0);
    check_output("loss_track_value", track_value, 0);
    repeat (3) @(negedge clk);

    // No signal: random chips
    mode = 1;
    apply_stimulus(1'b1);
    wait_level("nosig_done", 0, 1'b1, 130 * W, at);
    check_output("nosig_done_cycle", at, 128 * W + 1);
    check_output("nosig_below_thresh", best_value < 8'd192, 1);
    repeat (130) @(negedge clk);
    check_output("nosig_locked", locked, 0);
    check_output("nosig_idle", busy, 0);

    // Ties: constant score everywhere resolves to phase 0
    mode = 2;
    apply_stimulus(1'b1);
    wait_level("tie_done", 0, 1'b1, 130 * W, at);
    repeat (4) @(negedge clk);
    check_output("tie_best_phase", best_phase, 0);
    check_output("tie_best_value", best_value, 200);
    check_output("tie_locked", locked, 1);

    // Mid-scan abort at k=40, then rescan with an ignored second start
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mode = 0;
    @(negedge clk);
    apply_stimulus(1'b1);
    repeat (42 * W + W / 2 - 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("abort_busy", busy, 0);
    check_output("abort_code_out", code_out, 1);
    check_output("abort_best_value", best_value, 0);
    check_output("abort_locked", locked, 0);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(1'b1);
    repeat (10) @(negedge clk);
    apply_stimulus(1'b0);
    check_output("abort_busy_after_restart", busy, 1);
    wait_level("abort_done", 0, 1'b1, 130 * W, at);
    check_output("abort_done_cycle", at, 128 * W + 1);
    check_output("abort_best_phase", best_phase, 5);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
